// File: rtl/mips_defs.sv
// Shared processor definitions: default datapath and register-address widths,
// plus the hard-wired zero register that is never written.
package mips_defs;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam logic [DEF_REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_fifo.sv
// Per-channel writeback FIFO. Write data is visible at the head one edge after the push.
// The parent must gate push with !full and pop with !empty. Per-entry taps feed the hazard query.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int AW    = 5,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count,
  output logic [DEPTH-1:0]    ent_vld,
  output logic [DEPTH*AW-1:0] ent_reg
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  for (genvar e = 0; e < DEPTH; e++) begin : g_tap
    logic [PW-1:0] off;
    assign off                = PW'(e) - rd_ptr;
    assign ent_vld[e]         = ({1'b0, off} < count);
    assign ent_reg[e*AW +: AW] = mem[e][W-1 -: AW];
  end
endmodule

// File: rtl/wb_merge.sv
// Merges NUM_CH execute-unit result streams into one register-file write port via round-robin.
// Latency two edges from push to wb_*; in_ready drops when a channel buffer is full, overflow is sticky.
module wb_merge
  import mips_defs::*;
#(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*REG_AW-1:0] in_regdest,
  input  logic [NUM_CH*DATA_W-1:0] in_wbvalue,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     wb_reg_en,
  output logic [REG_AW-1:0]        wb_reg_addr,
  output logic [DATA_W-1:0]        wb_reg_data,
  input  logic [REG_AW-1:0]        query_addr,
  output logic                     query_pending,
  output logic [NUM_CH-1:0]        overflow
);
  localparam int EW = REG_AW + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [REG_AW-1:0] ZERO_DEST = REG_AW'(ZERO_REG);

  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH-1:0]        dest_nz;
  logic [NUM_CH-1:0]        fifo_full;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [CW-1:0]            fifo_cnt  [NUM_CH];
  logic [EW-1:0]            fifo_dout [NUM_CH];
  logic [DEPTH-1:0]         ent_vld   [NUM_CH];
  logic [DEPTH*REG_AW-1:0]  ent_reg   [NUM_CH];

  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant_idx;
  logic          grant_vld;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign dest_nz[g]  = (in_regdest[g*REG_AW +: REG_AW] != ZERO_DEST);
    assign in_ready[g] = (fifo_cnt[g] < CW'(DEPTH));
    assign push[g]     = in_valid[g] && in_ready[g] && dest_nz[g];

    wb_fifo #(.DEPTH(DEPTH), .W(EW), .AW(REG_AW)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push[g]),
      .pop     (pop[g]),
      .din     ({in_regdest[g*REG_AW +: REG_AW], in_wbvalue[g*DATA_W +: DATA_W]}),
      .dout    (fifo_dout[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .count   (fifo_cnt[g]),
      .ent_vld (ent_vld[g]),
      .ent_reg (ent_reg[g])
    );
  end

  // Round-robin: first non-empty channel strictly after the last one served.
  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(last_grant) + k) % NUM_CH;
      if (!grant_vld && !fifo_empty[c]) begin
        grant_vld = 1'b1;
        grant_idx = GW'(c);
      end
    end
  end

  assign pop = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg_en   <= 1'b0;
      wb_reg_addr <= '0;
      wb_reg_data <= '0;
      last_grant  <= GW'(NUM_CH - 1);
      overflow    <= '0;
    end else begin
      wb_reg_en <= grant_vld;
      if (grant_vld) begin
        {wb_reg_addr, wb_reg_data} <= fifo_dout[grant_idx];
        last_grant                 <= grant_idx;
      end
      overflow <= overflow | (in_valid & fifo_full & dest_nz);
    end
  end

  // Register 0 is never written, so it can never be pending.
  always_comb begin
    query_pending = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_vld[ch][e] && (ent_reg[ch][e*REG_AW +: REG_AW] == query_addr))
          query_pending = 1'b1;
      end
    end
    if (wb_reg_en && (wb_reg_addr == query_addr)) query_pending = 1'b1;
    if (query_addr == ZERO_DEST) query_pending = 1'b0;
  end
endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed table, hand sequences for overflow/query/reset, random traffic vs queue model.
module tb_wb_merge;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic                     clock;
  logic                     reset;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*REG_AW-1:0] in_regdest;
  logic [NUM_CH*DATA_W-1:0] in_wbvalue;
  logic [NUM_CH-1:0]        in_ready;
  logic                     wb_reg_en;
  logic [REG_AW-1:0]        wb_reg_addr;
  logic [DATA_W-1:0]        wb_reg_data;
  logic [REG_AW-1:0]        query_addr;
  logic                     query_pending;
  logic [NUM_CH-1:0]        overflow;

  wb_merge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_regdest    (in_regdest),
    .in_wbvalue    (in_wbvalue),
    .in_ready      (in_ready),
    .wb_reg_en     (wb_reg_en),
    .wb_reg_addr   (wb_reg_addr),
    .wb_reg_data   (wb_reg_data),
    .query_addr    (query_addr),
    .query_pending (query_pending),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  // Reference model: one queue per channel, a round-robin pointer, the output register.
  ent_t        mq [NUM_CH][$];
  int          m_last;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_ovf;

  typedef struct {
    logic        pre_rst;
    logic [2:0]  v;
    logic [14:0] rd;
    logic [95:0] wv;
    logic [4:0]  qa;
    logic [2:0]  e_rdy;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_qp;
    logic [2:0]  e_ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_pending(input logic [4:0] qa);
    logic p;
    p = 1'b0;
    if (qa != 5'd0) begin
      if (m_en && m_addr == qa) p = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        foreach (mq[i][j]) if (mq[i][j].r == qa) p = 1'b1;
    end
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    m_last = NUM_CH - 1;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_ovf  = '0;
  endtask

  // One clock: apply inputs, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] wv,
                       input logic [4:0] qa);
    logic [2:0] rdy_s;
    int         g;
    int         c;
    ent_t       e;
    in_valid   = v;
    in_regdest = rd;
    in_wbvalue = wv;
    query_addr = qa;
    #1;
    for (int i = 0; i < NUM_CH; i++) rdy_s[i] = (mq[i].size() < DEPTH);
    chk("in_ready", in_ready, rdy_s);
    chk("query_pending", query_pending, model_pending(qa));
    g = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (m_last + k) % NUM_CH;
      if (g < 0 && mq[c].size() > 0) g = c;
    end
    if (g >= 0) begin
      e      = mq[g].pop_front();
      m_en   = 1'b1;
      m_addr = e.r;
      m_data = e.d;
      m_last = g;
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i] && rd[i*5 +: 5] != 5'd0) begin
        if (rdy_s[i]) begin
          e.r = rd[i*5 +: 5];
          e.d = wv[i*32 +: 32];
          mq[i].push_back(e);
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("wb_reg_en", wb_reg_en, m_en);
    chk("wb_reg_addr", wb_reg_addr, m_addr);
    chk("wb_reg_data", wb_reg_data, m_data);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset(input bit mid_op);
    in_valid = '0;
    reset    = 1'b0;
    #1;
    if (mid_op) begin
      chk("reset_en_immediate", wb_reg_en, 1'b0);
      chk("reset_ovf_immediate", overflow, 3'b000);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_reset_ready", in_ready, 3'b111);
    chk("post_reset_en", wb_reg_en, 1'b0);
    chk("post_reset_addr", wb_reg_addr, 5'd0);
    chk("post_reset_data", wb_reg_data, 32'd0);
  endtask

  initial begin
    logic [14:0] rd;
    logic [95:0] wv;
    bit          saw_full;

    // pre_rst, v, rd{c2,c1,c0}, wv{c2,c1,c0}, qa | rdy, en, addr, data, qp, ovf (after the edge)
    tbl[0] = '{1'b0, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h1234}, 5'd3,
               3'b111, 1'b0, 5'd0, 32'h0,    1'b1, 3'b000};
    tbl[1] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd3,
               3'b111, 1'b1, 5'd3, 32'h1234, 1'b1, 3'b000};
    tbl[2] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd3,
               3'b111, 1'b0, 5'd3, 32'h1234, 1'b0, 3'b000};
    tbl[3] = '{1'b1, 3'b111, {5'd4, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 5'd4,
               3'b111, 1'b0, 5'd0, 32'h0,    1'b1, 3'b000};
    tbl[4] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd1,
               3'b111, 1'b1, 5'd1, 32'hA,    1'b1, 3'b000};
    tbl[5] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd2,
               3'b111, 1'b1, 5'd2, 32'hB,    1'b1, 3'b000};
    tbl[6] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd4,
               3'b111, 1'b1, 5'd4, 32'hC,    1'b1, 3'b000};
    tbl[7] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd4,
               3'b111, 1'b0, 5'd4, 32'hC,    1'b0, 3'b000};
    tbl[8] = '{1'b0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFF, 32'h0, 32'h0}, 5'd0,
               3'b111, 1'b0, 5'd4, 32'hC,    1'b0, 3'b000};
    tbl[9] = '{1'b0, 3'b000, 15'd0, 96'd0, 5'd0,
               3'b111, 1'b0, 5'd4, 32'hC,    1'b0, 3'b000};

    in_valid   = '0;
    in_regdest = '0;
    in_wbvalue = '0;
    query_addr = '0;
    reset      = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre_rst) do_reset(1'b0);
      cycle(tbl[i].v, tbl[i].rd, tbl[i].wv, tbl[i].qa);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_en", i), wb_reg_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_addr", i), wb_reg_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), wb_reg_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_qp", i), query_pending, tbl[i].e_qp);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
    end

    // Channel 1 floods while channels 0 and 2 keep the arbiter busy.
    do_reset(1'b0);
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!in_ready[1]) saw_full = 1'b1;
      cycle(3'b111, {5'(16 + i), 5'(8 + i), 5'(1 + i)},
            {32'(32'h200 + i), 32'(32'h100 + i), 32'(i)}, 5'd9);
    end
    for (int i = 0; i < 20; i++) cycle(3'b000, 15'd0, 96'd0, 5'd9);
    chk("flood_saw_full1", saw_full, 1'b1);
    chk("flood_ovf1", overflow[1], 1'b1);

    // Pending-write query for r7 buffered on channel 1.
    do_reset(1'b0);
    cycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 5'd7);
    chk("q7_buffered", query_pending, 1'b1);
    query_addr = 5'd8;
    #1;
    chk("q8_buffered", query_pending, 1'b0);
    cycle(3'b000, 15'd0, 96'd0, 5'd7);
    chk("q7_output", query_pending, 1'b1);
    chk("q7_output_en", wb_reg_en, 1'b1);
    cycle(3'b000, 15'd0, 96'd0, 5'd7);
    chk("q7_done", query_pending, 1'b0);

    // Reset while entries are buffered and a write is on the output.
    cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 5'd1);
    cycle(3'b111, {5'd6, 5'd5, 5'd4}, {32'h6, 32'h5, 32'h4}, 5'd1);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) cycle(3'b000, 15'd0, 96'd0, 5'd1);

    // Random traffic against the model.
    do_reset(1'b0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rd[i*5 +: 5]  = 5'($urandom_range(0, 7));
        wv[i*32 +: 32] = $urandom;
      end
      cycle(3'($urandom_range(0, 7)), rd, wv, 5'($urandom_range(0, 8)));
    end
    for (int i = 0; i < 16; i++) cycle(3'b000, 15'd0, 96'd0, 5'($urandom_range(0, 8)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 Parameter NUM_CH, default 3: number of execute-unit result channels (X, Y, M).
REQ-002 Parameter DEPTH, default 4, power of two, >=2: entries per channel buffer.
REQ-003 Parameter DATA_W, default 32: writeback value width.
REQ-004 Parameter REG_AW, default 5: register address width.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  NUM_CH  per-channel writereg strobe.
REQ-008 in_regdest  in  NUM_CH*REG_AW  per-channel destination; channel i at bits [i*REG_AW +: REG_AW].
REQ-009 in_wbvalue  in  NUM_CH*DATA_W  per-channel result; channel i at bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  out  NUM_CH  per-channel buffer not full.
REQ-011 wb_reg_en  out  1  register-file write enable.
REQ-012 wb_reg_addr  out  REG_AW  register-file write address.
REQ-013 wb_reg_data  out  DATA_W  register-file write data.
REQ-014 query_addr  in  REG_AW  register address probed by Issue for pending writes.
REQ-015 query_pending  out  1  some buffered or output-stage entry targets query_addr.
REQ-016 overflow  out  NUM_CH  sticky flag: push attempted while channel full.

Function
REQ-017 Channel i push when in_valid[i]=1, in_ready[i]=1, in_regdest[i]!=0: {regdest, value} written to tail of buffer i at the edge.
REQ-018 in_valid[i]=1 with in_regdest[i]=0 SHALL be discarded, never buffered, never flagged.
REQ-019 in_valid[i]=1 while in_ready[i]=0 SHALL drop the request and set overflow[i] at that edge; contents unchanged.
REQ-020 in_ready[i] = buffer i occupancy < DEPTH, combinational from registered occupancy only.
REQ-021 Each buffer SHALL be FIFO; entries of one channel leave in arrival order.
REQ-022 Each cycle, the arbiter grants at most one non-empty channel: first non-empty channel strictly after last_grant, cyclically (round-robin).
REQ-023 On a grant, the head entry pops and loads the output register at the same edge: wb_reg_en=1, wb_reg_addr/wb_reg_data = entry; with no grant, wb_reg_en=0 next cycle and addr/data hold.
REQ-024 last_grant updates only on a grant.
REQ-025 Latency: entry pushed at edge t into an empty buffer, uncontested, appears on wb_* during cycle after edge t+1.
REQ-026 Push and pop on the same channel in one edge SHALL both take effect; occupancy unchanged; a full buffer still reports in_ready=0 that cycle (no same-cycle bypass of full).
REQ-027 Pointers wrap modulo DEPTH; occupancy counter REG_AW-independent, width clog2(DEPTH)+1.
REQ-028 query_pending combinational: OR over all valid buffer entries and the output register (when wb_reg_en=1) of regdest==query_addr; query_addr=0 yields 0.
REQ-029 Cross-channel ordering to the same register is not enforced; Issue SHALL use query_pending to avoid such hazards.

Reset
REQ-030 reset low SHALL immediately clear all occupancies and pointers, wb_reg_en=0, wb_reg_addr=0, wb_reg_data=0, overflow=0, last_grant=NUM_CH-1 (channel 0 first).
REQ-031 Reset mid-operation discards all buffered entries; no write emitted for them after release.
REQ-032 in_ready all 1 the first cycle after reset release.

Structure
REQ-033 DATA_W and REG_AW defaults, and the zero-register constant, SHALL live in the shared mips_defs package/header used by Registers and Writeback.
REQ-034 One sub-module wb_fifo (parameters DEPTH, width REG_AW+DATA_W; push, pop, full, empty, count, per-entry valid/regdest taps for query) SHALL be instantiated NUM_CH times via generate.
REQ-035 Arbiter and output register SHALL be in wb_merge itself; no combinational path from in_* to wb_*.

Verification
REQ-036 Single push ch0 (r3, 0x1234) at edge 1 -> wb_reg_en=1, addr=3, data=0x1234 after edge 2 only, one cycle wide.
REQ-037 Same edge pushes ch0 r1=0xA, ch1 r2=0xB, ch2 r4=0xC after reset -> writes r1, r2, r4 on three consecutive cycles in that order.
REQ-038 DEPTH=4, ch1 pushes 6 back-to-back while ch0 continuously busy -> in_ready[1]=0 at occupancy 4, overflow[1]=1, exactly the accepted entries written in order.
REQ-039 Push ch2 r0=0xFFFF -> no write, query_pending for 0 stays 0, overflow unchanged.
REQ-040 Buffer r7 on ch1, query_addr=7 -> query_pending=1 until cycle after its write; query_addr=8 -> 0.
REQ-041 Assert reset with 3 entries buffered -> wb_reg_en=0 immediately, no writes after release, in_ready=all 1.
